// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, packed command type and issue FSM states shared by the ALU front-end
package alu_pkg;
    localparam logic [1:0] ALU_OP_ADD = 2'b00;
    localparam logic [1:0] ALU_OP_SUB = 2'b01;
    localparam logic [1:0] ALU_OP_MUL = 2'b10;
    localparam logic [1:0] ALU_OP_AND = 2'b11;
    typedef struct packed {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
    } alu_cmd_t;
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } alu_state_t;
endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous FIFO of alu_cmd_t, head visible on dout without a read cycle
// Ports: clk, rst_n (async active-low); push/din write side; pop/dout read side; full, empty status
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  alu_cmd_t din,
    input  logic     pop,
    output alu_cmd_t dout,
    output logic     full,
    output logic     empty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    alu_cmd_t      mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;
    assign full    = count == (AW+1)'(FIFO_DEPTH);
    assign empty   = count == '0;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
    // pointers wrap naturally because FIFO_DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: buffers ALU commands, issues one per cycle and holds results behind a valid/ready port
// Ports: clk, rst_n (async active-low); cmd_* command handshake in; alu_* issued operands out,
//        alu_result/alu_cout back from the ALU; res_* held result handshake out.
// Option: ALU_ISSUE_ZERO_FLAG_EN adds res_zero, captured as (alu_result == 0) alongside res_data.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    input  logic        cmd_cin,
    output logic [1:0]  alu_sel,
    output logic [3:0]  alu_a4,
    output logic [3:0]  alu_b4,
    output logic [5:0]  alu_a6,
    output logic [5:0]  alu_b6,
    output logic [7:0]  alu_a8,
    output logic [7:0]  alu_b8,
    output logic        alu_cin,
    input  logic [11:0] alu_result,
    input  logic        alu_cout,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [11:0] res_data,
    output logic        res_cout,
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    output logic        res_zero,
`endif
    output logic [1:0]  res_op
);
    alu_state_t state;
    alu_cmd_t   head, iss;
    logic       full, empty, capture, pop;
    alu_cmd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid),
        .din   ({cmd_op, cmd_a, cmd_b, cmd_cin}),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );
    assign cmd_ready = ~full;
    // capture may reuse the output slot on the same edge the consumer drains it
    assign capture = state == ST_EXEC && (!res_valid || res_ready);
    assign pop     = !empty && (state == ST_IDLE || capture);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            iss   <= '0;
        end else begin
            state <= pop ? ST_EXEC : capture ? ST_IDLE : state;
            if (pop) iss <= head;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_cout  <= 1'b0;
            res_op    <= '0;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
            res_zero  <= 1'b0;
`endif
        end else begin
            res_valid <= capture | (res_valid & ~res_ready);
            if (capture) begin
                res_data <= alu_result;
                res_cout <= alu_cout;
                res_op   <= iss.op;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
                res_zero <= alu_result == '0;
`endif
            end
        end
    end
    // ALU operands come straight from the issue register, so they hold while idle
    assign alu_sel = iss.op;
    assign alu_a4  = iss.a[3:0];
    assign alu_b4  = iss.b[3:0];
    assign alu_a6  = iss.a[5:0];
    assign alu_b6  = iss.b[5:0];
    assign alu_a8  = iss.a;
    assign alu_b8  = iss.b;
    assign alu_cin = iss.cin;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed checks of alu_issue_ctrl with a behavioural ALU attached
module tb_alu_issue_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_cin;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_a, cmd_b;
  logic [1:0]  alu_sel;
  logic [3:0]  alu_a4, alu_b4;
  logic [5:0]  alu_a6, alu_b6;
  logic [7:0]  alu_a8, alu_b8;
  logic        alu_cin;
  logic [11:0] alu_result;
  logic        alu_cout;
  logic        res_valid, res_ready, res_cout;
  logic [11:0] res_data;
  logic [1:0]  res_op;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
  logic        res_zero;
`endif
  int errors = 0;
  int checks = 0;
  alu_issue_ctrl #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_cin    (cmd_cin),
    .alu_sel    (alu_sel),
    .alu_a4     (alu_a4),
    .alu_b4     (alu_b4),
    .alu_a6     (alu_a6),
    .alu_b6     (alu_b6),
    .alu_a8     (alu_a8),
    .alu_b8     (alu_b8),
    .alu_cin    (alu_cin),
    .alu_result (alu_result),
    .alu_cout   (alu_cout),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_cout   (res_cout),
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    .res_zero   (res_zero),
`endif
    .res_op     (res_op)
  );
  always #5 clk = ~clk;
  function automatic logic [12:0] alu_model(input logic [1:0] op, input logic [3:0] a4, b4,
                                            input logic [5:0] a6, b6, input logic [7:0] a8, b8,
                                            input logic cin);
    logic [4:0] s;
    logic [8:0] d;
    s = {1'b0, a4} + {1'b0, b4} + {4'b0, cin};
    d = {1'b0, a8} - {1'b0, b8} - {8'b0, cin};
    case (op)
      2'b00:   return {s[4], 8'b0, s[3:0]};
      2'b01:   return {d[8], 4'b0, d[7:0]};
      2'b10:   return {1'b0, {6'b0, a6} * {6'b0, b6}};
      default: return {1'b0, 8'b0, a4 & b4};
    endcase
  endfunction
  function automatic logic [12:0] cmd_model(input logic [1:0] op, input logic [7:0] a, b, input logic cin);
    return alu_model(op, a[3:0], b[3:0], a[5:0], b[5:0], a, b, cin);
  endfunction
  assign {alu_cout, alu_result} = alu_model(alu_sel, alu_a4, alu_b4, alu_a6, alu_b6, alu_a8, alu_b8, alu_cin);
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_cin = 1'b0; res_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (res_valid !== 1'b0 || res_data !== 12'h000 || res_cout !== 1'b0 || res_op !== 2'b00) begin
      errors++;
      $display("FAIL reset_res: got valid=%b data=%h cout=%b op=%b want 0 000 0 00", res_valid, res_data, res_cout, res_op);
    end
    checks++;
    if ({alu_sel, alu_a8, alu_b8, alu_cin} !== 19'd0 || {alu_a4, alu_b4, alu_a6, alu_b6} !== 20'd0) begin
      errors++;
      $display("FAIL reset_alu: got sel=%b a8=%h b8=%h cin=%b want all zero", alu_sel, alu_a8, alu_b8, alu_cin);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", cmd_ready);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: got valid=%b ready=%b want 0 1", res_valid, cmd_ready);
    end
  endtask
  task automatic test_single_op(input string name, input logic [1:0] op, input logic [7:0] a, b,
                                input logic cin, input logic [11:0] exp_data, input logic exp_cout);
    res_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_cin = cin;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s accept_ready: got %b want 1", name, cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s early_valid_e0: got %b want 0", name, res_valid);
    end
    tick();
    checks++;
    if (alu_sel !== op || alu_a8 !== a || alu_b8 !== b || alu_cin !== cin ||
        alu_a4 !== a[3:0] || alu_b4 !== b[3:0] || alu_a6 !== a[5:0] || alu_b6 !== b[5:0]) begin
      errors++;
      $display("FAIL %s issue: got sel=%b a8=%h b8=%h a6=%h b6=%h a4=%h b4=%h cin=%b want %b %h %h", name,
               alu_sel, alu_a8, alu_b8, alu_a6, alu_b6, alu_a4, alu_b4, alu_cin, op, a, b);
    end
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s early_valid_e1: got %b want 0", name, res_valid);
    end
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_data !== exp_data || res_cout !== exp_cout || res_op !== op) begin
      errors++;
      $display("FAIL %s result: got valid=%b data=%h cout=%b op=%b want 1 %h %b %b", name,
               res_valid, res_data, res_cout, res_op, exp_data, exp_cout, op);
    end
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_data !== exp_data || res_cout !== exp_cout || res_op !== op) begin
      errors++;
      $display("FAIL %s hold: got valid=%b data=%h cout=%b op=%b want 1 %h %b %b", name,
               res_valid, res_data, res_cout, res_op, exp_data, exp_cout, op);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s drain: got valid=%b want 0", name, res_valid);
    end
    checks++;
    if (alu_sel !== op || alu_a8 !== a || alu_b8 !== b) begin
      errors++;
      $display("FAIL %s idle_hold: got sel=%b a8=%h b8=%h want %b %h %h", name, alu_sel, alu_a8, alu_b8, op, a, b);
    end
  endtask
`ifdef ALU_ISSUE_ZERO_FLAG_EN
  task automatic test_zero_flag();
    res_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_a = 8'h00; cmd_b = 8'h05; cmd_cin = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_data !== 12'h000 || res_zero !== 1'b1) begin
      errors++;
      $display("FAIL zero_mul: got valid=%b data=%h zero=%b want 1 000 1", res_valid, res_data, res_zero);
    end
    res_ready = 1'b1;
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = 8'h01; cmd_b = 8'h01; cmd_cin = 1'b0;
    tick();
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_data !== 12'h002 || res_zero !== 1'b0) begin
      errors++;
      $display("FAIL zero_add: got valid=%b data=%h zero=%b want 1 002 0", res_valid, res_data, res_zero);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask
`endif
  task automatic test_back_to_back();
    logic [1:0]  op_q [7];
    logic [7:0]  a_q [7];
    logic [7:0]  b_q [7];
    logic        c_q [7];
    logic [12:0] exp_q [7];
    logic        take, got7;
    for (int i = 0; i < 7; i++) begin
      op_q[i]  = 2'(i);
      a_q[i]   = 8'(37 * i + 5);
      b_q[i]   = 8'(11 * i + 200);
      c_q[i]   = i[0];
      exp_q[i] = cmd_model(op_q[i], a_q[i], b_q[i], c_q[i]);
    end
    res_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1; cmd_op = op_q[i]; cmd_a = a_q[i]; cmd_b = b_q[i]; cmd_cin = c_q[i];
      checks++;
      if (cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL bp_accept_%0d: got ready=%b want 1", i, cmd_ready);
      end
      tick();
    end
    cmd_op = op_q[6]; cmd_a = a_q[6]; cmd_b = b_q[6]; cmd_cin = c_q[6];
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: got ready=%b want 0", cmd_ready);
    end
    tick();
    checks++;
    if (cmd_ready !== 1'b0 || res_valid !== 1'b1 || {res_cout, res_data} !== exp_q[0]) begin
      errors++;
      $display("FAIL bp_stall: got ready=%b valid=%b res=%h want 0 1 %h", cmd_ready, res_valid, {res_cout, res_data}, exp_q[0]);
    end
    res_ready = 1'b1;
    got7 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (res_valid !== 1'b1 || {res_cout, res_data} !== exp_q[i] || res_op !== op_q[i]) begin
        errors++;
        $display("FAIL bp_result_%0d: got valid=%b res=%h op=%b want 1 %h %b", i, res_valid,
                 {res_cout, res_data}, res_op, exp_q[i], op_q[i]);
      end
      take = cmd_valid & cmd_ready;
      tick();
      if (take) begin
        cmd_valid = 1'b0;
        got7 = 1'b1;
      end
    end
    res_ready = 1'b0;
    checks++;
    if (got7 !== 1'b1) begin
      errors++;
      $display("FAIL bp_seventh_accept: got accepted=%b want 1", got7);
    end
    checks++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_empty: got valid=%b ready=%b want 0 1", res_valid, cmd_ready);
    end
  endtask
  task automatic test_streaming();
    logic [12:0] q [$];
    logic [1:0]  qop [$];
    int          results;
    results = 0;
    res_ready = 1'b0;
    cmd_valid = 1'b1;
    cmd_op = 2'($urandom_range(3, 0)); cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_cin = 1'($urandom);
    for (int s = 0; s < 40; s++) begin
      if (res_valid && res_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL stream_extra: got res=%h with no pending command want none", {res_cout, res_data});
        end else begin
          if ({res_cout, res_data} !== q[0] || res_op !== qop[0]) begin
            errors++;
            $display("FAIL stream_result_%0d: got res=%h op=%b want %h %b", results,
                     {res_cout, res_data}, res_op, q[0], qop[0]);
          end
          void'(q.pop_front());
          void'(qop.pop_front());
        end
        results++;
      end
      if (s >= 4 && s < 28) begin
        checks++;
        if (res_valid !== 1'b1) begin
          errors++;
          $display("FAIL stream_bubble_%0d: got valid=%b want 1", s, res_valid);
        end
      end
      if (s < 24) begin
        checks++;
        if (cmd_ready !== 1'b1) begin
          errors++;
          $display("FAIL stream_ready_%0d: got %b want 1", s, cmd_ready);
        end
      end
      if (cmd_valid && cmd_ready) begin
        q.push_back(cmd_model(cmd_op, cmd_a, cmd_b, cmd_cin));
        qop.push_back(cmd_op);
      end
      tick();
      cmd_valid = s + 1 < 24;
      res_ready = s + 1 >= 4;
      cmd_op = 2'($urandom_range(3, 0)); cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_cin = 1'($urandom);
    end
    res_ready = 1'b0;
    checks++;
    if (q.size() != 0 || results != 24) begin
      errors++;
      $display("FAIL stream_count: got results=%0d pending=%0d want 24 0", results, q.size());
    end
  endtask
  task automatic test_reset_mid();
    logic stale;
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1; cmd_op = 2'(i); cmd_a = 8'(i + 1); cmd_b = 8'(3 * i); cmd_cin = 1'b0;
      tick();
    end
    cmd_valid = 1'b0;
    checks++;
    if (res_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: got valid=%b want 1", res_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (res_valid !== 1'b0 || res_data !== 12'h000) begin
      errors++;
      $display("FAIL rstmid_async: got valid=%b data=%h want 0 000", res_valid, res_data);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_ready: got %b want 1", cmd_ready);
    end
    tick();
    rst_n = 1'b1;
    res_ready = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (res_valid) stale = 1'b1;
    end
    checks++;
    if (stale !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_stale: got a result after reset want none");
    end
    checks++;
    if (cmd_ready !== 1'b1 || alu_a8 !== 8'h00 || alu_sel !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_after: got ready=%b a8=%h sel=%b want 1 00 00", cmd_ready, alu_a8, alu_sel);
    end
    res_ready = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary want completion");
    $fatal(1, "timeout");
  end
  initial begin
    test_reset();
    test_single_op("add", 2'b00, 8'h09, 8'h08, 1'b0, 12'h001, 1'b1);
    test_single_op("sub", 2'b01, 8'h05, 8'h07, 1'b0, 12'h0FE, 1'b1);
    test_single_op("and", 2'b11, 8'h0C, 8'h0A, 1'b0, 12'h008, 1'b0);
    test_single_op("mul", 2'b10, 8'h3F, 8'h3F, 1'b0, 12'hF81, 1'b0);
    test_single_op("add_cin", 2'b00, 8'hF7, 8'h28, 1'b1, 12'h000, 1'b1);
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    test_zero_flag();
`endif
    test_back_to_back();
    test_streaming();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
